// File: rtl/lsu_mem_stage.sv
// Load/store unit in front of a word-wide data memory: validates each request,
// performs word-only memory accesses (read-modify-write for SB/SH) and returns a held response.
module lsu_mem_stage #(
  parameter int MEM_SIZE_KB = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_reqValid,
  output logic        o_reqReady,
  input  logic        i_reqWrite,
  input  logic [2:0]  i_reqFunct3,
  input  logic [31:0] i_reqAddr,
  input  logic [31:0] i_reqWdata,
  output logic        o_rspValid,
  input  logic        i_rspReady,
  output logic [31:0] o_rspRdata,
  output logic        o_rspErr,
  output logic        o_memRead,
  output logic        o_memWrite,
  output logic [31:0] o_memAddr,
  output logic [31:0] o_memWdata,
  output logic [2:0]  o_memFunct3,
  input  logic [31:0] i_memRdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [32:0] MEM_BYTES = 33'(MEM_SIZE_KB) * 33'd1024;

  logic [1:0]  state_reg, state_next;
  logic        write_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] word_reg;
  logic [31:0] rsp_rdata_reg;
  logic        rsp_err_reg;

  logic [1:0]  lane;
  logic        funct3_ok;
  logic        misaligned;
  logic        out_of_range;
  logic        req_err;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  assign lane = addr_reg[1:0];

  // Request validation works on the live inputs so the decision is ready at the accept edge.
  always_comb begin
    funct3_ok = 1'b0;
    case (i_reqFunct3)
      3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
      3'b100, 3'b101:         funct3_ok = !i_reqWrite;
      default:                funct3_ok = 1'b0;
    endcase
    misaligned   = ((i_reqFunct3[1:0] == 2'b01) && i_reqAddr[0]) ||
                   ((i_reqFunct3[1:0] == 2'b10) && (i_reqAddr[1:0] != 2'b00));
    out_of_range = ({1'b0, i_reqAddr} >= MEM_BYTES);
    req_err      = !funct3_ok || misaligned || out_of_range;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (i_reqValid) begin
          if (req_err)
            state_next = RESP;
          else if (i_reqWrite && (i_reqFunct3[1:0] == 2'b10))
            state_next = WRITE;
          else
            state_next = READ;
        end
      end
      READ:    state_next = write_reg ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = i_rspReady ? IDLE : RESP;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load_byte = i_memRdata[{lane, 3'b000} +: 8];
    load_half = i_memRdata[{lane[1], 4'b0000} +: 16];
    case (funct3_reg[1:0])
      2'b00:   load_data = {{24{!funct3_reg[2] && load_byte[7]}}, load_byte};
      2'b01:   load_data = {{16{!funct3_reg[2] && load_half[15]}}, load_half};
      default: load_data = i_memRdata;
    endcase
  end

  // Per-byte merge of store data into the word fetched during READ.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic       lane_hit;
      logic [7:0] store_byte;
      always_comb begin
        if (funct3_reg[1]) begin
          lane_hit   = 1'b1;
          store_byte = wdata_reg[8*gi +: 8];
        end else if (funct3_reg[0]) begin
          lane_hit   = (lane[1] == 1'(gi / 2));
          store_byte = wdata_reg[8*(gi % 2) +: 8];
        end else begin
          lane_hit   = (lane == 2'(gi));
          store_byte = wdata_reg[7:0];
        end
      end
      assign merged_word[8*gi +: 8] = lane_hit ? store_byte : word_reg[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= IDLE;
      write_reg     <= 1'b0;
      funct3_reg    <= 3'b000;
      addr_reg      <= 32'd0;
      wdata_reg     <= 32'd0;
      word_reg      <= 32'd0;
      rsp_rdata_reg <= 32'd0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (i_reqValid) begin
            write_reg     <= i_reqWrite;
            funct3_reg    <= i_reqFunct3;
            addr_reg      <= i_reqAddr;
            wdata_reg     <= i_reqWdata;
            rsp_err_reg   <= req_err;
            rsp_rdata_reg <= 32'd0;
          end
        end
        READ: begin
          word_reg <= i_memRdata;
          if (!write_reg)
            rsp_rdata_reg <= load_data;
        end
        RESP: begin
          if (i_rspReady) begin
            rsp_rdata_reg <= 32'd0;
            rsp_err_reg   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_reqReady  = (state_reg == IDLE);
  assign o_rspValid  = (state_reg == RESP);
  assign o_rspRdata  = rsp_rdata_reg;
  assign o_rspErr    = rsp_err_reg;
  assign o_memRead   = (state_reg == READ);
  // A reset edge coinciding with WRITE must never commit the word.
  assign o_memWrite  = (state_reg == WRITE) && !i_rst;
  assign o_memAddr   = {2'b00, addr_reg[31:2]};
  assign o_memWdata  = merged_word;
  assign o_memFunct3 = 3'b010;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed vector table, corner sequences
// and randomized traffic checked against a byte-level reference model.
module tb_lsu_mem_stage;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_reqValid = 1'b0;
  logic        o_reqReady;
  logic        i_reqWrite = 1'b0;
  logic [2:0]  i_reqFunct3 = 3'b000;
  logic [31:0] i_reqAddr = 32'd0;
  logic [31:0] i_reqWdata = 32'd0;
  logic        o_rspValid;
  logic        i_rspReady = 1'b0;
  logic [31:0] o_rspRdata;
  logic        o_rspErr;
  logic        o_memRead;
  logic        o_memWrite;
  logic [31:0] o_memAddr;
  logic [31:0] o_memWdata;
  logic [2:0]  o_memFunct3;
  logic [31:0] i_memRdata;

  int checks = 0;
  int errors = 0;
  int excl_viol = 0;

  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];

  lsu_mem_stage #(.MEM_SIZE_KB(1)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_reqValid(i_reqValid), .o_reqReady(o_reqReady), .i_reqWrite(i_reqWrite),
    .i_reqFunct3(i_reqFunct3), .i_reqAddr(i_reqAddr), .i_reqWdata(i_reqWdata),
    .o_rspValid(o_rspValid), .i_rspReady(i_rspReady), .o_rspRdata(o_rspRdata),
    .o_rspErr(o_rspErr), .o_memRead(o_memRead), .o_memWrite(o_memWrite),
    .o_memAddr(o_memAddr), .o_memWdata(o_memWdata), .o_memFunct3(o_memFunct3),
    .i_memRdata(i_memRdata)
  );

  always #5 i_clk = ~i_clk;

  // Data memory: combinational read, write on the rising edge.
  assign i_memRdata = mem[o_memAddr[7:0]];
  always @(posedge i_clk) if (o_memWrite) mem[o_memAddr[7:0]] <= o_memWdata;
  always @(negedge i_clk) if (o_memRead && o_memWrite) excl_viol++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: byte-granular semantics of RV32 loads/stores on a 1 KB memory.
  function automatic void model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] word,
                                output logic [31:0] rdata, output logic err, output int lat,
                                output int rd, output int wrc, output logic [31:0] new_word);
    int size, off;
    logic legal;
    logic [63:0] mask, v;
    size = 1 << f3[1:0];
    off = int'(addr % 4);
    legal = wr ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err = !legal || (addr % size != 0) || (addr >= 32'd1024);
    new_word = word;
    rdata = 32'd0;
    if (err) begin
      lat = 1; rd = 0; wrc = 0;
    end else if (!wr) begin
      mask = (64'd1 << (8 * size)) - 64'd1;
      v = (64'(word) >> (8 * off)) & mask;
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
      rdata = v[31:0];
      lat = 2; rd = 1; wrc = 0;
    end else begin
      for (int i = 0; i < size; i++) new_word[8*(off+i) +: 8] = wd[8*i +: 8];
      lat = (size == 4) ? 2 : 3;
      rd = (size == 4) ? 0 : 1;
      wrc = 1;
    end
  endfunction

  // Issue one request starting at a negedge; holds the response for 'hold' extra cycles.
  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int rd, output int wrc);
    rd = 0; wrc = 0; lat = 0; rdata = 32'd0; err = 1'b0;
    check("req_ready_idle", 32'(o_reqReady), 32'd1);
    i_reqValid = 1'b1; i_reqWrite = wr; i_reqFunct3 = f3; i_reqAddr = addr; i_reqWdata = wd;
    @(posedge i_clk); @(negedge i_clk);
    i_reqValid = 1'b0;
    lat = 1;
    rd += int'(o_memRead); wrc += int'(o_memWrite);
    while (!o_rspValid && lat < 20) begin
      @(posedge i_clk); @(negedge i_clk);
      lat++;
      rd += int'(o_memRead); wrc += int'(o_memWrite);
    end
    if (!o_rspValid) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: got no response expected response within 20 cycles");
    end
    rdata = o_rspRdata; err = o_rspErr;
    for (int h = 0; h < hold; h++) begin
      @(posedge i_clk); @(negedge i_clk);
      check("hold_valid", 32'(o_rspValid), 32'd1);
      check("hold_rdata", o_rspRdata, rdata);
      check("hold_ready_low", 32'(o_reqReady), 32'd0);
      check("hold_no_mem", 32'({o_memRead, o_memWrite}), 32'd0);
    end
    i_rspReady = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    i_rspReady = 1'b0;
    $display("txn wr=%0b f3=%0d addr=%h wd=%h -> rdata=%h err=%0b lat=%0d", wr, f3, addr, wd,
             rdata, err, lat);
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rd;
    int          wrc;
  } vec_t;

  vec_t vecs [16];

  initial begin
    logic [31:0] rdata, e_rdata, e_word, old_word;
    logic err, e_err, wr;
    logic [2:0] f3;
    logic [31:0] addr, wd;
    int lat, rd, wrc, e_lat, e_rd, e_wrc, hold;

    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[16] = 32'h8844_2211;
    mem[32] = 32'h0000_0000;
    mem[48] = 32'h1122_3344;

    vecs[0]  = '{1'b0, 3'b000, 32'h43,  32'h0,         32'hFFFF_FF88, 1'b0, 2, 1, 0};
    vecs[1]  = '{1'b0, 3'b100, 32'h43,  32'h0,         32'h0000_0088, 1'b0, 2, 1, 0};
    vecs[2]  = '{1'b0, 3'b101, 32'h42,  32'h0,         32'h0000_8844, 1'b0, 2, 1, 0};
    vecs[3]  = '{1'b1, 3'b000, 32'h41,  32'h0000_00AB, 32'h0,         1'b0, 3, 1, 1};
    vecs[4]  = '{1'b0, 3'b010, 32'h40,  32'h0,         32'h8844_AB11, 1'b0, 2, 1, 0};
    vecs[5]  = '{1'b1, 3'b010, 32'h80,  32'hDEAD_BEEF, 32'h0,         1'b0, 2, 0, 1};
    vecs[6]  = '{1'b0, 3'b010, 32'h80,  32'h0,         32'hDEAD_BEEF, 1'b0, 2, 1, 0};
    vecs[7]  = '{1'b0, 3'b010, 32'h42,  32'h0,         32'h0,         1'b1, 1, 0, 0};
    vecs[8]  = '{1'b1, 3'b001, 32'h41,  32'h0000_1234, 32'h0,         1'b1, 1, 0, 0};
    vecs[9]  = '{1'b0, 3'b011, 32'h40,  32'h0,         32'h0,         1'b1, 1, 0, 0};
    vecs[10] = '{1'b0, 3'b010, 32'h400, 32'h0,         32'h0,         1'b1, 1, 0, 0};
    vecs[11] = '{1'b0, 3'b001, 32'h42,  32'h0,         32'hFFFF_8844, 1'b0, 2, 1, 0};
    vecs[12] = '{1'b1, 3'b011, 32'h40,  32'h0,         32'h0,         1'b1, 1, 0, 0};
    vecs[13] = '{1'b0, 3'b000, 32'h41,  32'h0,         32'hFFFF_FFAB, 1'b0, 2, 1, 0};
    vecs[14] = '{1'b1, 3'b001, 32'h82,  32'h1234_5678, 32'h0,         1'b0, 3, 1, 1};
    vecs[15] = '{1'b0, 3'b010, 32'h80,  32'h0,         32'h5678_BEEF, 1'b0, 2, 1, 0};

    // Reset state
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_rsp_valid", 32'(o_rspValid), 32'd0);
    check("rst_rsp_err", 32'(o_rspErr), 32'd0);
    check("rst_rsp_rdata", o_rspRdata, 32'd0);
    check("rst_mem_rw", 32'({o_memRead, o_memWrite}), 32'd0);
    check("rst_mem_addr", o_memAddr, 32'd0);
    check("mem_funct3", 32'(o_memFunct3), 32'd2);
    i_rst = 1'b0;
    @(posedge i_clk); @(negedge i_clk);
    check("req_ready_after_rst", 32'(o_reqReady), 32'd1);

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      do_req(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wd, 0, rdata, err, lat, rd, wrc);
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].rdata);
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].err));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_reads", i), 32'(rd), 32'(vecs[i].rd));
      check($sformatf("vec%0d_writes", i), 32'(wrc), 32'(vecs[i].wrc));
    end
    check("mem_word10_after_sb", mem[16], 32'h8844_AB11);

    // Backpressure: response held 5 cycles, next request accepted right after release
    do_req(1'b0, 3'b010, 32'h40, 32'h0, 5, rdata, err, lat, rd, wrc);
    check("bp_rdata", rdata, 32'h8844_AB11);
    check("bp_lat", 32'(lat), 32'd2);
    do_req(1'b0, 3'b100, 32'h40, 32'h0, 0, rdata, err, lat, rd, wrc);
    check("bp_next_rdata", rdata, 32'h0000_0011);
    check("bp_next_lat", 32'(lat), 32'd2);

    // Reset asserted during the WRITE cycle of an SH
    i_reqValid = 1'b1; i_reqWrite = 1'b1; i_reqFunct3 = 3'b001;
    i_reqAddr = 32'hC2; i_reqWdata = 32'h0000_BEEF;
    @(posedge i_clk); @(negedge i_clk);
    i_reqValid = 1'b0;
    check("sh_read_cycle", 32'(o_memRead), 32'd1);
    @(posedge i_clk); @(negedge i_clk);
    check("sh_write_cycle", 32'(o_memWrite), 32'd1);
    i_rst = 1'b1;
    #1;
    check("sh_write_gated", 32'(o_memWrite), 32'd0);
    @(posedge i_clk); @(negedge i_clk);
    check("midrst_rsp_valid", 32'(o_rspValid), 32'd0);
    check("midrst_rsp_err", 32'(o_rspErr), 32'd0);
    check("midrst_rsp_rdata", o_rspRdata, 32'd0);
    check("midrst_mem_rw", 32'({o_memRead, o_memWrite}), 32'd0);
    check("midrst_mem_word", mem[48], 32'h1122_3344);
    i_rst = 1'b0;
    @(posedge i_clk); @(negedge i_clk);
    check("midrst_req_ready", 32'(o_reqReady), 32'd1);
    check("midrst_rsp_idle", 32'(o_rspValid), 32'd0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    for (int n = 0; n < 300; n++) begin
      wr = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      addr = 32'($urandom_range(0, 1151));
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b01) addr[0] = 1'b0;
        if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
      end
      wd = $urandom;
      hold = $urandom_range(0, 2);
      old_word = (addr < 32'd1024) ? ref_mem[addr[9:2]] : 32'd0;
      model(wr, f3, addr, wd, old_word, e_rdata, e_err, e_lat, e_rd, e_wrc, e_word);
      if (!e_err && wr) ref_mem[addr[9:2]] = e_word;
      do_req(wr, f3, addr, wd, hold, rdata, err, lat, rd, wrc);
      check("rnd_rdata", rdata, e_rdata);
      check("rnd_err", 32'(err), 32'(e_err));
      check("rnd_lat", 32'(lat), 32'(e_lat));
      check("rnd_reads", 32'(rd), 32'(e_rd));
      check("rnd_writes", 32'(wrc), 32'(e_wrc));
      if (addr < 32'd1024) check("rnd_mem_word", mem[addr[9:2]], ref_mem[addr[9:2]]);
    end

    check("read_write_exclusive", 32'(excl_viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit sitting directly upstream of the data memory.
- Accepts one memory request from the execute stage over a valid/ready handshake and checks alignment and range.
- Drives word-only accesses into the data memory, using read-modify-write for SB/SH.
- Returns sign/zero-extended load data or store completion over a held response handshake.

Parameters:
MEM_SIZE_KB, 1, data memory size in KB; byte addresses >= MEM_SIZE_KB*1024 are out of range.

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_rst  in  1  synchronous active-high reset
i_reqValid  in  1  request present
o_reqReady  out  1  unit can accept; high only in IDLE
i_reqWrite  in  1  1=store, 0=load
i_reqFunct3  in  3  RV32 load/store funct3
i_reqAddr  in  32  byte address
i_reqWdata  in  32  store data; low byte/half used for SB/SH
o_rspValid  out  1  response available, held until accepted
i_rspReady  in  1  consumer accepts response
o_rspRdata  out  32  extended load data; 0 for stores and errors
o_rspErr  out  1  misaligned, out-of-range or illegal funct3
o_memRead  out  1  data memory read enable
o_memWrite  out  1  data memory write enable
o_memAddr  out  32  word index = i_reqAddr >> 2 (captured)
o_memWdata  out  32  full word to write
o_memFunct3  out  3  constant 3'b010 (word access)
i_memRdata  in  32  combinational read data from data memory

Behaviour:
- Clock is i_clk. Reset is i_rst: synchronous, active-high.
- Reset: state=IDLE; o_rspValid=0, o_rspErr=0, o_rspRdata=0; o_memRead=0, o_memWrite=0; captured registers=0.
- o_memWrite is gated by !i_rst, so a reset edge never commits a write.
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - o_reqReady=1.
  - On i_reqValid, capture write flag, funct3, addr, wdata and lane = addr[1:0].
  - Next state:
    - error -> RESP with err=1;
    - load -> READ;
    - SW -> WRITE;
    - SB/SH -> READ.
- Error conditions:
  - Load funct3 not in {000,001,010,100,101}.
  - Store funct3 not in {000,001,010}.
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
  - addr >= MEM_SIZE_KB*1024.
  - On error: no memory access is issued, o_rspRdata=0.
- READ:
  - o_memRead=1, o_memAddr=word index; o_memFunct3 is always 3'b010.
  - At the end of the cycle, register i_memRdata as the captured word.
  - Load -> RESP with extracted data. Store -> WRITE.
- Load extraction:
  - LB/LBU: byte [8*lane+7 : 8*lane], sign- or zero-extended.
  - LH/LHU: half [16*lane[1]+15 : 16*lane[1]], sign- or zero-extended.
  - LW: whole word.
- WRITE (exactly one cycle):
  - o_memWrite=1.
  - SW: o_memWdata = wdata.
  - SB: captured word with byte lane replaced by wdata[7:0].
  - SH: captured word with half lane[1] replaced by wdata[15:0].
  - Next state: RESP.
- RESP:
  - o_rspValid=1 with rdata/err stable until i_rspReady.
  - On i_rspValid&i_rspReady -> IDLE; o_reqReady rises the following cycle (no same-cycle re-accept).
- Latency from the accept edge T:
  - Error: rspValid at T+1.
  - Load or SW: rspValid at T+2.
  - SB/SH: rspValid at T+3.
- Backpressure: i_rspReady low holds RESP indefinitely. No memory signals are asserted in RESP or IDLE.
- o_memRead and o_memWrite are never high together.
- Requests arriving while not ready are ignored; the requester must hold i_reqValid.
- Reset mid-operation: immediate return to IDLE, in-flight response dropped, no partial write.

Test Plan:
- Preload mem word 0x10 (byte addr 0x40) = 0x8844_2211. LB @0x43 -> rspRdata=0xFFFF_FF88, err=0, rspValid 2 cycles after accept. LBU @0x43 -> 0x0000_0088. LHU @0x42 -> 0x0000_8844.
- SB 0xAB @0x41 over 0x8844_2211 -> READ then WRITE of 0x8844_AB11 at word 0x10. Response at T+3 with rdata=0. A following LW @0x40 returns 0x8844_AB11.
- SW 0xDEAD_BEEF @0x80 -> no READ cycle, one-cycle o_memWrite with wdata 0xDEADBEEF at word 0x20, response at T+2.
- Error cases, each giving rspErr=1, rdata=0 at T+1 with o_memRead and o_memWrite never asserted:
  - LW @0x42;
  - SH @0x41;
  - load funct3=011;
  - LW @0x400 with MEM_SIZE_KB=1.
- Backpressure: hold i_rspReady=0 for 5 cycles after LW. rspValid and rdata stay stable and o_reqReady=0 throughout. Raise ready -> IDLE, next request accepted one cycle later.
- Assert i_rst during the WRITE cycle of SH -> memory word unchanged, all outputs at reset values on the next cycle, o_reqReady=1 after reset drops.
